// File: rtl/bit_scan_enc.sv
`default_nettype none
// ============================================================================
// Module   : bit_scan_enc
// Purpose  : Sequential priority encoder. Accepts a WIDTH-bit vector over a
//            valid/ready handshake and emits the index of every set bit, one
//            index per output beat. Each beat clears the reported bit from an
//            internal copy of the vector. An all-zero vector yields a single
//            beat flagged out_empty.
// Ports    : clk        rising-edge clock
//            rst_n      asynchronous active-low reset
//            in_valid   in_data is valid
//            in_ready   block can accept a vector this cycle
//            in_data    vector to scan (WIDTH bits)
//            out_valid  out_pos / out_last / out_empty are valid
//            out_ready  consumer accepts the current beat
//            out_pos    index of the current set bit (POS_W bits)
//            out_last   current beat is the final beat for this vector
//            out_empty  accepted vector was all-zero; beat carries no index
// Config   : BIT_SCAN_MSB_FIRST_EN - when defined, beats are emitted highest
//            set index first; otherwise lowest index first.
// Revision : 1.0 - initial release
// ============================================================================
module bit_scan_enc #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] out_pos,
  output logic                     out_last,
  output logic                     out_empty
);

  localparam int POS_W = $clog2(WIDTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_vec;
  logic [WIDTH-1:0]   w_vec_nxt;
  logic [POS_W-1:0]   w_pos;
  logic [WIDTH-1:0]   w_clr_mask;
  logic               w_scan;
  logic               w_multi;
  logic               w_xfer;
  logic               w_accept;

  // Single-stage priority select. The loop direction makes the last match
  // win, so iterating downward picks the lowest set bit and upward the highest.
  always_comb begin
    w_pos = '0;
`ifdef BIT_SCAN_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (r_vec[i]) w_pos = POS_W'(i);
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (r_vec[i]) w_pos = POS_W'(i);
    end
`endif
  end

  // x & (x-1) drops the lowest set bit; anything left means two or more bits.
  assign w_multi    = |(r_vec & (r_vec - WIDTH'(1)));
  assign w_clr_mask = ~(WIDTH'(1) << w_pos);

  assign w_scan     = (r_state == ST_SCAN);
  assign out_valid  = w_scan;
  assign out_pos    = w_scan ? w_pos : '0;
  assign out_last   = w_scan & ~w_multi;
  assign out_empty  = w_scan & ~(|r_vec);

  assign w_xfer     = out_valid & out_ready;
  // A new vector may be taken on the same edge the final beat leaves, which
  // is what lets consecutive vectors stream without a bubble.
  assign in_ready   = ~w_scan | (w_xfer & out_last);
  assign w_accept   = in_valid & in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SCAN;
          w_vec_nxt   = in_data;
        end
      end
      ST_SCAN: begin
        if (w_xfer) begin
          w_vec_nxt = r_vec & w_clr_mask;
          if (out_last) begin
            if (w_accept) begin
              w_vec_nxt = in_data;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_vec_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_vec   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bit_scan_enc.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_scan_enc
// Purpose  : Self-checking bench for bit_scan_enc (WIDTH=8). A queue-based
//            reference model tracks the indices still owed for the current
//            vector and is compared against the DUT every cycle; directed
//            table vectors, a back-to-back sequence, a mid-scan reset and a
//            randomized phase drive it.
// Config   : BIT_SCAN_MSB_FIRST_EN selects highest-index-first expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_scan_enc;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_pos;
  logic       out_last;
  logic       out_empty;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  bit_scan_enc #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pos   (out_pos),
    .out_last  (out_last),
    .out_empty (out_empty)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model: queue of indices still to emit --------
  int mq[$];
  bit m_busy = 1'b0;

  function automatic void m_load(logic [7:0] d);
    mq.delete();
`ifdef BIT_SCAN_MSB_FIRST_EN
    for (int i = 7; i >= 0; i--) if (d[i]) mq.push_back(i);
`else
    for (int i = 0; i < 8; i++) if (d[i]) mq.push_back(i);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_busy = 1'b0;
    end else begin
      bit last;
      bit rdy;
      bit acc;
      last = (mq.size() <= 1);
      rdy  = !m_busy || (out_ready && last);
      acc  = in_valid && rdy;
      if (m_busy && out_ready) begin
        if (mq.size() > 0) void'(mq.pop_front());
        if (last) m_busy = 1'b0;
      end
      if (acc) begin
        m_load(in_data);
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      bit e_last;
      e_last = (mq.size() <= 1);
      chk("mon_out_valid", out_valid, m_busy);
      if (m_busy) begin
        chk("mon_out_pos", out_pos, (mq.size() > 0) ? mq[0] : 0);
        chk("mon_out_last", out_last, e_last);
        chk("mon_out_empty", out_empty, mq.size() == 0);
      end
      chk("mon_in_ready", in_ready, !m_busy || (out_ready && e_last));
    end
  end

  // ---------------- directed table ------------------------------------------
  typedef struct {
    logic [7:0] data;
    int         nb;
    int         pos[8];
    bit         stall;
  } vec_t;

  vec_t tbl[5];

  task automatic run_vec(input vec_t v);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    in_valid  = 1'b1;
    in_data   = v.data;
    out_ready = 1'b1;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);   // must not disturb the held vector
    chk("first_beat_latency", out_valid, 1);
    cyc = 0;
    while (got < v.nb && cyc < 100) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        chk("beat_pos", out_pos, v.pos[got]);
        chk("beat_last", out_last, got == v.nb - 1);
        chk("beat_empty", out_empty, v.data == 8'h00);
        if (got == v.nb - 1) chk("last_beat_in_ready", in_ready, 1);
        got++;
      end
      @(posedge clk); #1;
      cyc++;
      if (v.stall) out_ready = ~out_ready;
    end
    chk("beat_count", got, v.nb);
    chk("idle_after_vector", out_valid, 0);
    out_ready = 1'b1;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pos", out_pos, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_empty", out_empty, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    mon_en = 1'b1;

`ifdef BIT_SCAN_MSB_FIRST_EN
    tbl[0] = '{data: 8'hA4, nb: 3, pos: '{7, 5, 2, 0, 0, 0, 0, 0}, stall: 1'b0};
    tbl[2] = '{data: 8'hFF, nb: 8, pos: '{7, 6, 5, 4, 3, 2, 1, 0}, stall: 1'b1};
`else
    tbl[0] = '{data: 8'hA4, nb: 3, pos: '{2, 5, 7, 0, 0, 0, 0, 0}, stall: 1'b0};
    tbl[2] = '{data: 8'hFF, nb: 8, pos: '{0, 1, 2, 3, 4, 5, 6, 7}, stall: 1'b1};
`endif
    tbl[1] = '{data: 8'h00, nb: 1, pos: '{0, 0, 0, 0, 0, 0, 0, 0}, stall: 1'b0};
    tbl[3] = '{data: 8'h01, nb: 1, pos: '{0, 0, 0, 0, 0, 0, 0, 0}, stall: 1'b0};
    tbl[4] = '{data: 8'h80, nb: 1, pos: '{7, 0, 0, 0, 0, 0, 0, 0}, stall: 1'b1};

    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) run_vec(tbl[k]);

    // back-to-back 8'h81 then 8'h02 with no bubble
    in_valid = 1'b1;
    in_data  = 8'h81;
    @(posedge clk); #1;
    in_data = 8'h02;
    @(negedge clk);
`ifdef BIT_SCAN_MSB_FIRST_EN
    chk("b2b_beat0_pos", out_pos, 7);
`else
    chk("b2b_beat0_pos", out_pos, 0);
`endif
    chk("b2b_beat0_last", out_last, 0);
    chk("b2b_beat0_in_ready", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
`ifdef BIT_SCAN_MSB_FIRST_EN
    chk("b2b_beat1_pos", out_pos, 0);
`else
    chk("b2b_beat1_pos", out_pos, 7);
`endif
    chk("b2b_beat1_last", out_last, 1);
    chk("b2b_beat1_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_beat2_valid", out_valid, 1);
    chk("b2b_beat2_pos", out_pos, 1);
    chk("b2b_beat2_last", out_last, 1);
    @(posedge clk); #1;
    chk("b2b_idle", out_valid, 0);

    // reset pulsed during the second beat of 8'hF0
    in_valid = 1'b1;
    in_data  = 8'hF0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_after_idle", out_valid, 0);
    run_vec(tbl[3]);

    // randomized phase, checked by the per-cycle model
    for (int c = 0; c < 600; c++) begin
      int sel;
      in_valid  = ($urandom_range(0, 2) != 0);
      sel       = $urandom_range(0, 5);
      case (sel)
        0:       in_data = 8'h00;
        1:       in_data = 8'h01 << $urandom_range(0, 7);
        default: in_data = 8'($urandom);
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
    end
    chk("final_idle", out_valid, 0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1 (bench did not complete)");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
